// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Multicycle sequencer for the MIPS datapath: FETCH -> DECODE -> EXEC ->
//   (MEM) -> (WB) -> FETCH. Drives the datapath control word, PC/IR load
//   enables and req/ack handshakes to instruction and data memory, so the
//   core works with variable-latency memories.
//
//   Optional feature macro: CTRL_TIMEOUT_EN
//     defined   : a wait counter traps the FSM when a memory ack does not
//                 arrive within TIMEOUT_CYCLES request cycles.
//     undefined : memories are waited on indefinitely.
//
// Ports
//   clock        in   1         system clock, rising edge
//   reset        in   1         asynchronous active-high reset
//   instruction  in   32        IR contents (opcode [31:26], funct [5:0])
//   zero         in   1         ALU zero flag
//   imem_ack     in   1         instruction memory done pulse
//   dmem_ack     in   1         data memory done pulse
//   imem_req     out  1         instruction fetch request
//   dmem_req     out  1         data memory request
//   dmem_we      out  1         data memory write (with dmem_req)
//   ir_en        out  1         latch fetched word into IR
//   pc_en        out  1         load PC from sel_pc mux
//   rf_we        out  1         register file write
//   sel_wa       out  2         00=rt 01=rd 10=$31
//   sel_alu_b    out  1         0=rt 1=sign-extended imm
//   sel_result   out  2         00=alu_out 01=dmem rd 10=pc+4
//   sel_pc       out  2         00=pc+4 01=branch 10=jump 11=rs
//   alu_ctrl     out  4         0=AND 1=OR 2=ADD 6=SUB 7=SLT
//   halted       out  1         FSM in TRAP
//   err_code     out  2         00 none 01 illegal 10 imem tmo 11 dmem tmo
//   retired      out  RETIRE_W  count of pc_en cycles (wraps)
//
// State    | meaning
// ---------+--------------------------------------------------------------
// S_FETCH  | imem_req high until imem_ack; ir_en on the ack cycle
// S_DECODE | classify IR; unsupported encodings go to TRAP
// S_EXEC   | ALU operation; branches/jumps complete here
// S_MEM    | dmem_req high until dmem_ack; sw completes here
// S_WB     | register file write and PC increment
// S_TRAP   | halted; left only through reset
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RETIRE_W       = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         instruction,
    input  logic                zero,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                ir_en,
    output logic                pc_en,
    output logic                rf_we,
    output logic [1:0]          sel_wa,
    output logic                sel_alu_b,
    output logic [1:0]          sel_result,
    output logic [1:0]          sel_pc,
    output logic [3:0]          alu_ctrl,
    output logic                halted,
    output logic [1:0]          err_code,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd6;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_err;
    logic [1:0]          w_err_next;
    logic [RETIRE_W-1:0] r_retired;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_is_r;
    logic       w_is_jr;
    logic       w_r_alu_ok;
    logic [3:0] w_alu_r;
    logic       w_legal;
    logic       w_wait_tc;

    // Unreduced control word; gated by reset below.
    logic       w_imem_req, w_dmem_req, w_dmem_we, w_ir_en, w_pc_en, w_rf_we;
    logic [1:0] w_sel_wa, w_sel_result, w_sel_pc;
    logic       w_sel_alu_b, w_halted;
    logic [3:0] w_alu_ctrl;

    logic       w_unused_instr;
    assign w_unused_instr = ^instruction[25:6];

    assign w_op    = instruction[31:26];
    assign w_funct = instruction[5:0];
    assign w_is_r  = (w_op == OP_RTYPE);
    assign w_is_jr = w_is_r && (w_funct == FN_JR);

    always_comb begin
        w_r_alu_ok = 1'b1;
        w_alu_r    = 4'd0;
        case (w_funct)
            6'h20:   w_alu_r = ALU_ADD;
            6'h22:   w_alu_r = ALU_SUB;
            6'h24:   w_alu_r = 4'd0;
            6'h25:   w_alu_r = 4'd1;
            6'h2a:   w_alu_r = 4'd7;
            default: w_r_alu_ok = 1'b0;
        endcase
    end

    assign w_legal = (w_is_r && (w_r_alu_ok || w_is_jr)) ||
                     (w_op == OP_LW)  || (w_op == OP_SW)   ||
                     (w_op == OP_BEQ) || (w_op == OP_ADDI) ||
                     (w_op == OP_J)   || (w_op == OP_JAL);

`ifdef CTRL_TIMEOUT_EN
    // Down-counter reloaded on entry to a waiting state; terminal count
    // on a request cycle without ack means the memory has timed out.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] r_wait;

    assign w_wait_tc = (r_wait == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait <= TW'(TIMEOUT_CYCLES - 1);
        end else if ((w_state_next != r_state) &&
                     ((w_state_next == S_FETCH) || (w_state_next == S_MEM))) begin
            r_wait <= TW'(TIMEOUT_CYCLES - 1);
        end else if (((r_state == S_FETCH) && !imem_ack) ||
                     ((r_state == S_MEM) && !dmem_ack)) begin
            if (r_wait != '0) r_wait <= r_wait - 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_wait_tc        = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err_next   = 2'b00;
        w_imem_req   = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_ir_en      = 1'b0;
        w_pc_en      = 1'b0;
        w_rf_we      = 1'b0;
        w_sel_wa     = 2'b00;
        w_sel_alu_b  = 1'b0;
        w_sel_result = 2'b00;
        w_sel_pc     = 2'b00;
        w_alu_ctrl   = 4'd0;
        w_halted     = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    w_ir_en      = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_wait_tc) begin
                    w_state_next = S_TRAP;
                    w_err_next   = 2'b10;
                end
            end

            S_DECODE: begin
                if (w_legal) begin
                    w_state_next = S_EXEC;
                end else begin
                    w_state_next = S_TRAP;
                    w_err_next   = 2'b01;
                end
            end

            S_EXEC: begin
                if (w_is_jr) begin
                    w_pc_en      = 1'b1;
                    w_sel_pc     = 2'b11;
                    w_state_next = S_FETCH;
                end else if (w_is_r) begin
                    w_alu_ctrl   = w_alu_r;
                    w_state_next = S_WB;
                end else begin
                    case (w_op)
                        OP_BEQ: begin
                            w_alu_ctrl   = ALU_SUB;
                            w_pc_en      = 1'b1;
                            w_sel_pc     = zero ? 2'b01 : 2'b00;
                            w_state_next = S_FETCH;
                        end
                        OP_J: begin
                            w_pc_en      = 1'b1;
                            w_sel_pc     = 2'b10;
                            w_state_next = S_FETCH;
                        end
                        OP_JAL: begin
                            w_pc_en      = 1'b1;
                            w_sel_pc     = 2'b10;
                            w_rf_we      = 1'b1;
                            w_sel_wa     = 2'b10;
                            w_sel_result = 2'b10;
                            w_state_next = S_FETCH;
                        end
                        OP_ADDI: begin
                            w_alu_ctrl   = ALU_ADD;
                            w_sel_alu_b  = 1'b1;
                            w_state_next = S_WB;
                        end
                        default: begin
                            // lw / sw: address calculation
                            w_alu_ctrl   = ALU_ADD;
                            w_sel_alu_b  = 1'b1;
                            w_state_next = S_MEM;
                        end
                    endcase
                end
            end

            S_MEM: begin
                w_dmem_req  = 1'b1;
                w_dmem_we   = (w_op == OP_SW);
                w_alu_ctrl  = ALU_ADD;
                w_sel_alu_b = 1'b1;
                if (dmem_ack) begin
                    if (w_op == OP_SW) begin
                        w_pc_en      = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (w_wait_tc) begin
                    w_state_next = S_TRAP;
                    w_err_next   = 2'b11;
                end
            end

            S_WB: begin
                w_rf_we      = 1'b1;
                w_pc_en      = 1'b1;
                w_state_next = S_FETCH;
                if (w_is_r) begin
                    w_sel_wa = 2'b01;
                end else if (w_op == OP_LW) begin
                    w_sel_result = 2'b01;
                end
            end

            S_TRAP: begin
                w_halted = 1'b1;
            end

            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= 2'b00;
        end else if ((w_state_next == S_TRAP) && (r_state != S_TRAP)) begin
            r_err <= w_err_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (pc_en) begin
            r_retired <= r_retired + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

    // Outputs are forced low for as long as reset is held, so an
    // in-flight request drops in the same cycle reset rises.
    assign imem_req   = reset ? 1'b0  : w_imem_req;
    assign dmem_req   = reset ? 1'b0  : w_dmem_req;
    assign dmem_we    = reset ? 1'b0  : w_dmem_we;
    assign ir_en      = reset ? 1'b0  : w_ir_en;
    assign pc_en      = reset ? 1'b0  : w_pc_en;
    assign rf_we      = reset ? 1'b0  : w_rf_we;
    assign sel_wa     = reset ? 2'b00 : w_sel_wa;
    assign sel_alu_b  = reset ? 1'b0  : w_sel_alu_b;
    assign sel_result = reset ? 2'b00 : w_sel_result;
    assign sel_pc     = reset ? 2'b00 : w_sel_pc;
    assign alu_ctrl   = reset ? 4'd0  : w_alu_ctrl;
    assign halted     = reset ? 1'b0  : w_halted;
    assign err_code   = r_err;
    assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic        zero = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_en, pc_en, rf_we;
    logic [1:0]  sel_wa, sel_result, sel_pc, err_code;
    logic        sel_alu_b, halted;
    logic [3:0]  alu_ctrl;
    logic [31:0] retired;

    multicycle_controller #(.TIMEOUT_CYCLES(16), .RETIRE_W(32)) dut (
        .clock(clock), .reset(reset), .instruction(instruction), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_en(ir_en), .pc_en(pc_en),
        .rf_we(rf_we), .sel_wa(sel_wa), .sel_alu_b(sel_alu_b),
        .sel_result(sel_result), .sel_pc(sel_pc), .alu_ctrl(alu_ctrl),
        .halted(halted), .err_code(err_code), .retired(retired)
    );

    always #5 clock = ~clock;

    // Control word in a fixed order so a whole cycle is compared at once.
    logic [17:0] ctrl;
    assign ctrl = {imem_req, dmem_req, dmem_we, ir_en, pc_en, rf_we, sel_wa,
                   sel_alu_b, sel_result, sel_pc, alu_ctrl, halted};

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ret  = 0;
    logic [17:0] e;

    function automatic logic [17:0] cw(input logic ireq, input logic dreq,
            input logic dwe, input logic ir, input logic pc, input logic rf,
            input logic [1:0] wa, input logic alub, input logic [1:0] res,
            input logic [1:0] spc, input logic [3:0] alu, input logic hlt);
        return {ireq, dreq, dwe, ir, pc, rf, wa, alub, res, spc, alu, hlt};
    endfunction

    // Advance to 1 time unit after the next rising edge; acks are pulses.
    task automatic adv();
        @(posedge clock);
        #1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_checks++;
        if (ctrl !== 18'h0 || retired !== 32'd0 || err_code !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs: ctrl=%h retired=%0d err=%0d required 0/0/0", ctrl, retired, err_code);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        #3;
        e = cw(1,0,0,0,0,0,2'b00,0,2'b00,2'b00,4'd0,0);
        n_checks++;
        if (ctrl !== e) begin
            n_fail++;
            $display("FAIL reset_release_fetch: ctrl=%h required %h", ctrl, e);
        end
        exp_ret = 0;
    endtask

    task automatic test_add();
        instruction = 32'h00221820;
        imem_ack = 1'b1;
        #3;
        e = cw(1,0,0,1,0,0,2'b00,0,2'b00,2'b00,4'd0,0);
        n_checks++;
        if (ctrl !== e) begin n_fail++; $display("FAIL add_fetch: ctrl=%h required %h", ctrl, e); end
        adv();
        dmem_ack = 1'b1;   // stray ack with no request pending
        imem_ack = 1'b1;
        #3;
        n_checks++;
        if (ctrl !== 18'h0) begin n_fail++; $display("FAIL add_decode: ctrl=%h required 0", ctrl); end
        adv();
        #3;
        e = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,4'd2,0);
        n_checks++;
        if (ctrl !== e) begin n_fail++; $display("FAIL add_exec: ctrl=%h required %h", ctrl, e); end
        adv();
        #3;
        e = cw(0,0,0,0,1,1,2'b01,0,2'b00,2'b00,4'd0,0);
        n_checks++;
        if (ctrl !== e) begin n_fail++; $display("FAIL add_wb_cycle4: ctrl=%h required %h", ctrl, e); end
        adv();
        exp_ret++;
        #3;
        n_checks++;
        if (retired !== 32'(exp_ret) || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL add_retired: retired=%0d imem_req=%b required %0d/1", retired, imem_req, exp_ret);
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] instrs [5] = '{32'h00221822, 32'h00221824, 32'h00221825, 32'h0022182A, 32'h20220005};
        logic [3:0]  alus   [5] = '{4'd6, 4'd0, 4'd1, 4'd7, 4'd2};
        for (int i = 0; i < 5; i++) begin
            instruction = instrs[i];
            imem_ack = 1'b1;
            adv();
            adv();
            #3;
            e = cw(0,0,0,0,0,0,2'b00,(i == 4),2'b00,2'b00,alus[i],0);
            n_checks++;
            if (ctrl !== e) begin n_fail++; $display("FAIL alu_exec_%0d: ctrl=%h required %h", i, ctrl, e); end
            adv();
            #3;
            e = cw(0,0,0,0,1,1,(i == 4) ? 2'b00 : 2'b01,0,2'b00,2'b00,4'd0,0);
            n_checks++;
            if (ctrl !== e) begin n_fail++; $display("FAIL alu_wb_%0d: ctrl=%h required %h", i, ctrl, e); end
            adv();
            exp_ret++;
        end
    endtask

    task automatic test_lw_delayed();
        int cyc;
        int req_cycles;
        instruction = 32'h8C0A00FF;
        imem_ack = 1'b1;
        cyc = 1;
        adv(); cyc++;                 // DECODE
        adv(); cyc++;                 // EXEC
        #3;
        e = cw(0,0,0,0,0,0,2'b00,1,2'b00,2'b00,4'd2,0);
        n_checks++;
        if (ctrl !== e) begin n_fail++; $display("FAIL lw_exec: ctrl=%h required %h", ctrl, e); end
        adv(); cyc++;                 // MEM
        req_cycles = 0;
        for (int k = 0; k < 3; k++) begin
            dmem_ack = (k == 2);
            #3;
            if (dmem_req === 1'b1) req_cycles++;
            e = cw(0,1,0,0,0,0,2'b00,1,2'b00,2'b00,4'd2,0);
            n_checks++;
            if (ctrl !== e) begin n_fail++; $display("FAIL lw_mem_%0d: ctrl=%h required %h", k, ctrl, e); end
            adv(); cyc++;
        end
        n_checks++;
        if (req_cycles !== 3) begin n_fail++; $display("FAIL lw_req_cycles: got %0d required 3", req_cycles); end
        #3;
        e = cw(0,0,0,0,1,1,2'b00,0,2'b01,2'b00,4'd0,0);
        n_checks++;
        if (ctrl !== e) begin n_fail++; $display("FAIL lw_wb: ctrl=%h required %h", ctrl, e); end
        adv(); cyc++;
        exp_ret++;
        #3;
        // Eight cycles from the fetch request to the next fetch request.
        n_checks++;
        if (imem_req !== 1'b1 || cyc !== 8 || retired !== 32'(exp_ret)) begin
            n_fail++;
            $display("FAIL lw_total: imem_req=%b cycle=%0d retired=%0d required 1/8/%0d", imem_req, cyc, retired, exp_ret);
        end
    endtask

    task automatic test_sw();
        instruction = 32'hAC0A00FF;
        imem_ack = 1'b1;
        adv();
        adv();
        #3;
        e = cw(0,0,0,0,0,0,2'b00,1,2'b00,2'b00,4'd2,0);
        n_checks++;
        if (ctrl !== e) begin n_fail++; $display("FAIL sw_exec: ctrl=%h required %h", ctrl, e); end
        adv();
        dmem_ack = 1'b1;
        #3;
        e = cw(0,1,1,0,1,0,2'b00,1,2'b00,2'b00,4'd2,0);
        n_checks++;
        if (ctrl !== e) begin n_fail++; $display("FAIL sw_mem_cycle4: ctrl=%h required %h", ctrl, e); end
        adv();
        exp_ret++;
        #3;
        n_checks++;
        if (imem_req !== 1'b1 || rf_we !== 1'b0 || retired !== 32'(exp_ret)) begin
            n_fail++;
            $display("FAIL sw_done: imem_req=%b rf_we=%b retired=%0d required 1/0/%0d", imem_req, rf_we, retired, exp_ret);
        end
    endtask

    task automatic test_branch_jump();
        logic [31:0] instrs [5] = '{32'h10220003, 32'h10220003, 32'h08000010, 32'h0C000010, 32'h03E00008};
        logic        zs     [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [17:0] exps   [5];
        exps[0] = cw(0,0,0,0,1,0,2'b00,0,2'b00,2'b01,4'd6,0);
        exps[1] = cw(0,0,0,0,1,0,2'b00,0,2'b00,2'b00,4'd6,0);
        exps[2] = cw(0,0,0,0,1,0,2'b00,0,2'b00,2'b10,4'd0,0);
        exps[3] = cw(0,0,0,0,1,1,2'b10,0,2'b10,2'b10,4'd0,0);
        exps[4] = cw(0,0,0,0,1,0,2'b00,0,2'b00,2'b11,4'd0,0);
        for (int i = 0; i < 5; i++) begin
            instruction = instrs[i];
            zero = zs[i];
            imem_ack = 1'b1;
            adv();
            adv();
            #3;
            n_checks++;
            if (ctrl !== exps[i]) begin n_fail++; $display("FAIL branch_jump_%0d_cycle3: ctrl=%h required %h", i, ctrl, exps[i]); end
            adv();
            exp_ret++;
            #3;
            n_checks++;
            if (imem_req !== 1'b1 || retired !== 32'(exp_ret)) begin
                n_fail++;
                $display("FAIL branch_jump_%0d_next: imem_req=%b retired=%0d required 1/%0d", i, imem_req, retired, exp_ret);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_fetch_wait();
        instruction = 32'h00221820;
        for (int k = 0; k < 3; k++) begin
            imem_ack = (k == 2);
            #3;
            e = cw(1,0,0,(k == 2),0,0,2'b00,0,2'b00,2'b00,4'd0,0);
            n_checks++;
            if (ctrl !== e) begin n_fail++; $display("FAIL fetch_wait_%0d: ctrl=%h required %h", k, ctrl, e); end
            adv();
        end
        adv();
        imem_ack = 1'b1;   // ignored: EXEC has no request pending
        #3;
        e = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,4'd2,0);
        n_checks++;
        if (ctrl !== e) begin n_fail++; $display("FAIL fetch_wait_exec: ctrl=%h required %h", ctrl, e); end
        adv();
        adv();
        exp_ret++;
    endtask

    task automatic test_illegal(input logic [31:0] instr);
        instruction = instr;
        imem_ack = 1'b1;
        adv();
        adv();
        for (int k = 0; k < 3; k++) begin
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            #3;
            e = cw(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,4'd0,1);
            n_checks++;
            if (ctrl !== e || err_code !== 2'b01 || retired !== 32'(exp_ret)) begin
                n_fail++;
                $display("FAIL illegal_%h_trap_%0d: ctrl=%h err=%0d retired=%0d required %h/1/%0d", instr, k, ctrl, err_code, retired, e, exp_ret);
            end
            adv();
        end
        reset = 1'b1;
        #3;
        n_checks++;
        if (ctrl !== 18'h0 || err_code !== 2'b00 || retired !== 32'd0) begin
            n_fail++;
            $display("FAIL illegal_reset: ctrl=%h err=%0d retired=%0d required 0/0/0", ctrl, err_code, retired);
        end
        adv();
        reset = 1'b0;
        exp_ret = 0;
        #3;
        n_checks++;
        if (imem_req !== 1'b1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_recover: imem_req=%b halted=%b required 1/0", imem_req, halted);
        end
    endtask

    task automatic test_reset_mid_mem();
        instruction = 32'h8C0A00FF;
        imem_ack = 1'b1;
        adv();
        adv();
        adv();
        #3;
        n_checks++;
        if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL midmem_req: dmem_req=%b required 1", dmem_req); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 18'h0) begin n_fail++; $display("FAIL midmem_reset_drop: ctrl=%h required 0", ctrl); end
        adv();
        reset = 1'b0;
        exp_ret = 0;
        #3;
        e = cw(1,0,0,0,0,0,2'b00,0,2'b00,2'b00,4'd0,0);
        n_checks++;
        if (ctrl !== e || retired !== 32'd0) begin
            n_fail++;
            $display("FAIL midmem_fetch: ctrl=%h retired=%0d required %h/0", ctrl, retired, e);
        end
    endtask

`ifdef CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int req_cycles;
        reset = 1'b1;
        adv();
        reset = 1'b0;
        req_cycles = 0;
        for (int k = 0; k < 20 && halted !== 1'b1; k++) begin
            #3;
            if (imem_req === 1'b1) req_cycles++;
            adv();
        end
        #3;
        n_checks++;
        if (halted !== 1'b1 || err_code !== 2'b10 || req_cycles !== 16) begin
            n_fail++;
            $display("FAIL imem_timeout: halted=%b err=%0d req_cycles=%0d required 1/2/16", halted, err_code, req_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_lw_delayed();
        test_sw();
        test_branch_jump();
        test_fetch_wait();
        test_illegal(32'hFC000000);
        test_illegal(32'h0022183F);
        test_reset_mid_mem();
`ifdef CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
